// File: rtl/tcm_mem_pkg.sv
// Shared types and constants for the tightly-coupled memory model.
package tcm_mem_pkg;

    // Upper bound on per-port response latency
    localparam int LAT_MAX = 8;

    // Reset value for the stall LFSR; must be nonzero
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    localparam int TAG_W = 11;

    // One-hot maintenance-op encoding, assembled as {flush, writeback, invalidate}
    typedef enum logic [2:0] {
        MOP_NONE  = 3'b000,
        MOP_INV   = 3'b001,
        MOP_WB    = 3'b010,
        MOP_FLUSH = 3'b100
    } mop_e;

    typedef struct packed {
        logic        error;
        logic [63:0] inst;
    } i_resp_t;

    typedef struct packed {
        logic             error;
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
    } d_resp_t;

    // True when more than one maintenance op is requested at once
    function automatic logic multi_op(input logic [2:0] ops);
        return (ops[0] & ops[1]) | (ops[0] & ops[2]) | (ops[1] & ops[2]);
    endfunction

endpackage

// File: rtl/tcm_resp_pipe.sv
// Fixed-latency response delay line. Stage 1 is loaded on the accept edge,
// stage LATENCY drives the output. kill drops every stage including the one
// being loaded and masks the current output, so nothing in flight survives.
module tcm_resp_pipe #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             kill,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat
);

    logic [LATENCY:1] vld_pipe;
    logic [WIDTH-1:0] dat_pipe [1:LATENCY];

    // Shift valid/data one stage per cycle; empty slots carry zero data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            for (int s = 1; s <= LATENCY; s++) dat_pipe[s] <= '0;
        end else if (kill) begin
            vld_pipe <= '0;
            for (int s = 1; s <= LATENCY; s++) dat_pipe[s] <= '0;
        end else begin
            vld_pipe[1] <= in_vld;
            dat_pipe[1] <= in_vld ? in_dat : '0;
            for (int s = 2; s <= LATENCY; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                dat_pipe[s] <= dat_pipe[s-1];
            end
        end
    end

    assign out_vld = vld_pipe[LATENCY] & ~kill;
    assign out_dat = out_vld ? dat_pipe[LATENCY] : '0;

endmodule

// File: rtl/tcm_mem_lat.sv
// Dual-port TCM: 64-bit fetch port, tagged 32-bit data port, backdoor loader.
// Optional feature macro: TCM_MEM_STALL_EN (LFSR-driven accept stalls).
module tcm_mem_lat
    import tcm_mem_pkg::*;
#(
    parameter int          MEM_SIZE   = 65536,
    parameter int          I_LATENCY  = 1,
    parameter int          D_LATENCY  = 1,
    parameter logic [15:0] STALL_SEED = DEFAULT_SEED
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             mem_i_rd_i,
    input  logic             mem_i_flush_i,
    input  logic             mem_i_invalidate_i,
    input  logic [31:0]      mem_i_pc_i,
    output logic             mem_i_accept_o,
    output logic             mem_i_valid_o,
    output logic             mem_i_error_o,
    output logic [63:0]      mem_i_inst_o,
    input  logic [31:0]      mem_d_addr_i,
    input  logic [31:0]      mem_d_data_wr_i,
    input  logic             mem_d_rd_i,
    input  logic [3:0]       mem_d_wr_i,
    input  logic             mem_d_cacheable_i,
    input  logic [TAG_W-1:0] mem_d_req_tag_i,
    input  logic             mem_d_invalidate_i,
    input  logic             mem_d_writeback_i,
    input  logic             mem_d_flush_i,
    output logic             mem_d_accept_o,
    output logic             mem_d_ack_o,
    output logic             mem_d_error_o,
    output logic [31:0]      mem_d_data_rd_o,
    output logic [TAG_W-1:0] mem_d_resp_tag_o,
    input  logic             bd_wr_i,
    input  logic [31:0]      bd_addr_i,
    input  logic [31:0]      bd_data_i
);

    localparam int          WORDS    = MEM_SIZE / 4;
    localparam int          AW       = $clog2(WORDS);
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);

    logic [31:0] mem [WORDS];

    // ---------------------------------------------------------------- accept
`ifdef TCM_MEM_STALL_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR, taps 16,14,13,11, free-running from the seed
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lfsr <= STALL_SEED;
        else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign mem_i_accept_o = rst_ni & (|lfsr[1:0]);
    assign mem_d_accept_o = rst_ni & (|lfsr[9:8]);
`else
    logic unused_seed;
    assign unused_seed    = ^STALL_SEED;
    assign mem_i_accept_o = rst_ni;
    assign mem_d_accept_o = rst_ni;
`endif

    // Inputs the model deliberately ignores
    logic unused_in;
    assign unused_in = mem_i_invalidate_i ^ mem_d_cacheable_i;

    // ---------------------------------------------------------------- fetch
    logic          i_take, i_oor;
    logic [AW-2:0] i_widx;
    i_resp_t       i_req, i_rsp;

    assign i_take = mem_i_rd_i & mem_i_accept_o;
    assign i_oor  = mem_i_pc_i >= MEM_LIMIT;
    assign i_widx = mem_i_pc_i[AW+1:3];

    // RAM is read combinationally in the accept cycle, so a same-cycle write
    // (committed on the edge) is not visible here: old data is returned.
    always_comb begin
        i_req.error = i_oor;
        i_req.inst  = '0;
        if (!i_oor) i_req.inst = {mem[{i_widx, 1'b1}], mem[{i_widx, 1'b0}]};
    end

    tcm_resp_pipe #(.WIDTH($bits(i_resp_t)), .LATENCY(I_LATENCY)) u_i_pipe (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .kill    (mem_i_flush_i),
        .in_vld  (i_take),
        .in_dat  (i_req),
        .out_vld (mem_i_valid_o),
        .out_dat (i_rsp)
    );

    assign mem_i_error_o = i_rsp.error;
    assign mem_i_inst_o  = i_rsp.inst;

    // ---------------------------------------------------------------- data
    logic          d_wr_any, d_req, d_take, d_oor, d_we;
    logic [2:0]    d_ops;
    logic [AW-1:0] d_idx;
    d_resp_t       d_req_rsp, d_rsp;

    assign d_ops    = {mem_d_flush_i, mem_d_writeback_i, mem_d_invalidate_i};
    assign d_wr_any = |mem_d_wr_i;
    assign d_req    = mem_d_rd_i | d_wr_any | (d_ops != MOP_NONE);
    assign d_take   = d_req & mem_d_accept_o;
    assign d_oor    = mem_d_addr_i >= MEM_LIMIT;
    assign d_idx    = mem_d_addr_i[AW+1:2];
    assign d_we     = d_take & d_wr_any & ~d_oor;

    // Writes win over a simultaneous read; only a pure in-range read returns data
    always_comb begin
        d_req_rsp.error = ((mem_d_rd_i | d_wr_any) & d_oor)
                        | (mem_d_rd_i & d_wr_any)
                        | multi_op(d_ops);
        d_req_rsp.data  = '0;
        d_req_rsp.tag   = mem_d_req_tag_i;
        if (mem_d_rd_i && !d_wr_any && !d_oor) d_req_rsp.data = mem[d_idx];
    end

    tcm_resp_pipe #(.WIDTH($bits(d_resp_t)), .LATENCY(D_LATENCY)) u_d_pipe (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .kill    (1'b0),
        .in_vld  (d_take),
        .in_dat  (d_req_rsp),
        .out_vld (mem_d_ack_o),
        .out_dat (d_rsp)
    );

    assign mem_d_error_o    = d_rsp.error;
    assign mem_d_data_rd_o  = d_rsp.data;
    assign mem_d_resp_tag_o = d_rsp.tag;

    // ---------------------------------------------------------------- RAM
    logic          bd_we;
    logic [AW-1:0] bd_idx;

    assign bd_we  = bd_wr_i & (bd_addr_i < MEM_LIMIT);
    assign bd_idx = bd_addr_i[AW+1:2];

    // RAM write: data-port byte lanes first, backdoor last so it overrides
    // every byte when both hit the same word. Contents survive reset.
    always_ff @(posedge clk_i) begin
        if (d_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_d_wr_i[b]) mem[d_idx][8*b +: 8] <= mem_d_data_wr_i[8*b +: 8];
        end
        if (bd_we) mem[bd_idx] <= bd_data_i;
    end

endmodule

// File: tb/tb_tcm_mem_lat.sv
// Directed bench for tcm_mem_lat: vector table on the D port plus hand-built
// timing sequences (pipelined write/read, flush, reset, read-during-write).
module tb_tcm_mem_lat;

    localparam int MEM_SIZE = 65536;
    localparam int I_LAT    = 3;
    localparam int D_LAT    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_rd, i_flush, i_inv;
    logic [31:0] i_pc;
    logic [31:0] d_addr, d_wdata;
    logic        d_rd, d_cache, d_inv, d_wb, d_fl;
    logic [3:0]  d_wr;
    logic [10:0] d_tag;
    logic        bd_wr;
    logic [31:0] bd_addr, bd_data;

    logic        i_acc, i_vld, i_err;
    logic [63:0] i_inst;
    logic        d_acc, d_ack, d_err;
    logic [31:0] d_rdata;
    logic [10:0] d_rtag;

    logic        i4_acc, i4_vld, i4_err;
    logic [63:0] i4_inst;
    logic        d4_acc, d4_ack, d4_err;
    logic [31:0] d4_rdata;
    logic [10:0] d4_rtag;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tcm_mem_lat #(.MEM_SIZE(MEM_SIZE), .I_LATENCY(I_LAT), .D_LATENCY(D_LAT)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .mem_i_rd_i(i_rd), .mem_i_flush_i(i_flush), .mem_i_invalidate_i(i_inv), .mem_i_pc_i(i_pc),
        .mem_i_accept_o(i_acc), .mem_i_valid_o(i_vld), .mem_i_error_o(i_err), .mem_i_inst_o(i_inst),
        .mem_d_addr_i(d_addr), .mem_d_data_wr_i(d_wdata), .mem_d_rd_i(d_rd), .mem_d_wr_i(d_wr),
        .mem_d_cacheable_i(d_cache), .mem_d_req_tag_i(d_tag), .mem_d_invalidate_i(d_inv),
        .mem_d_writeback_i(d_wb), .mem_d_flush_i(d_fl), .mem_d_accept_o(d_acc), .mem_d_ack_o(d_ack),
        .mem_d_error_o(d_err), .mem_d_data_rd_o(d_rdata), .mem_d_resp_tag_o(d_rtag),
        .bd_wr_i(bd_wr), .bd_addr_i(bd_addr), .bd_data_i(bd_data)
    );

    // Second instance with a 4-cycle fetch latency, sharing all inputs
    tcm_mem_lat #(.MEM_SIZE(MEM_SIZE), .I_LATENCY(4), .D_LATENCY(1)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .mem_i_rd_i(i_rd), .mem_i_flush_i(i_flush), .mem_i_invalidate_i(i_inv), .mem_i_pc_i(i_pc),
        .mem_i_accept_o(i4_acc), .mem_i_valid_o(i4_vld), .mem_i_error_o(i4_err), .mem_i_inst_o(i4_inst),
        .mem_d_addr_i(d_addr), .mem_d_data_wr_i(d_wdata), .mem_d_rd_i(d_rd), .mem_d_wr_i(d_wr),
        .mem_d_cacheable_i(d_cache), .mem_d_req_tag_i(d_tag), .mem_d_invalidate_i(d_inv),
        .mem_d_writeback_i(d_wb), .mem_d_flush_i(d_fl), .mem_d_accept_o(d4_acc), .mem_d_ack_o(d4_ack),
        .mem_d_error_o(d4_err), .mem_d_data_rd_o(d4_rdata), .mem_d_resp_tag_o(d4_rtag),
        .bd_wr_i(bd_wr), .bd_addr_i(bd_addr), .bd_data_i(bd_data)
    );

    typedef struct {
        string       name;
        logic        rd;
        logic [3:0]  wr;
        logic [2:0]  ops;   // {flush, writeback, invalidate}
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [10:0] tag;
        logic        err;
        logic [31:0] data;
    } dvec_t;

    dvec_t tbl [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic d_drive(input logic rd, input logic [3:0] wr, input logic [2:0] ops,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [10:0] tag);
        d_rd = rd; d_wr = wr; {d_fl, d_wb, d_inv} = ops;
        d_addr = addr; d_wdata = wdata; d_tag = tag;
    endtask

    task automatic bd(input logic [31:0] addr, input logic [31:0] data);
        bd_wr = 1'b1; bd_addr = addr; bd_data = data;
        tick();
        bd_wr = 1'b0;
    endtask

    // Hold the inputs until accepted, then measure latency and check the response
    task automatic d_txn(input dvec_t v);
        int w = 0;
        int n = 1;
        d_drive(v.rd, v.wr, v.ops, v.addr, v.wdata, v.tag);
        while (!d_acc && w < 200) begin tick(); w++; end
        if (w >= 200) chk({v.name, ".accept_timeout"}, 0, 1);
        tick();
        d_drive(0, 0, 0, 0, 0, 0);
        while (!d_ack && n < 20) begin tick(); n++; end
        chk({v.name, ".lat"},  n, D_LAT);
        chk({v.name, ".err"},  d_err, v.err);
        chk({v.name, ".data"}, d_rdata, v.data);
        chk({v.name, ".tag"},  d_rtag, v.tag);
        tick();
    endtask

    task automatic fetch_chk(input string name, input logic [31:0] pc,
                             input logic err, input logic [63:0] inst);
        int w = 0;
        int n = 1;
        i_rd = 1'b1; i_pc = pc;
        while (!i_acc && w < 200) begin tick(); w++; end
        if (w >= 200) chk({name, ".accept_timeout"}, 0, 1);
        tick();
        i_rd = 1'b0;
        while (!i_vld && n < 20) begin tick(); n++; end
        chk({name, ".lat"},  n, I_LAT);
        chk({name, ".err"},  i_err, err);
        chk({name, ".inst"}, i_inst, inst);
        repeat (3) tick();   // let the slower instance drain
    endtask

    initial begin
        int cnt3, cnt4, at3, at4;
        logic [63:0] inst3, inst4;

        //             name       rd  wr    ops     addr          wdata         tag     err  data
        tbl[0]  = '{"rd_w0",     1, 4'h0, 3'b000, 32'h0,        32'h0,        11'h001, 0, 32'h11223344};
        tbl[1]  = '{"rd_unal",   1, 4'h0, 3'b000, 32'h6,        32'h0,        11'h002, 0, 32'h55667788};
        tbl[2]  = '{"wr_full",   0, 4'hF, 3'b000, 32'h200,      32'hFFFFFFFF, 11'h003, 0, 32'h0};
        tbl[3]  = '{"rd_full",   1, 4'h0, 3'b000, 32'h200,      32'h0,        11'h004, 0, 32'hFFFFFFFF};
        tbl[4]  = '{"wr_b3",     0, 4'h8, 3'b000, 32'h200,      32'h12345678, 11'h7FF, 0, 32'h0};
        tbl[5]  = '{"rd_b3",     1, 4'h0, 3'b000, 32'h200,      32'h0,        11'h400, 0, 32'h12FFFFFF};
        tbl[6]  = '{"rd_oor",    1, 4'h0, 3'b000, 32'h10000,    32'h0,        11'h005, 1, 32'h0};
        tbl[7]  = '{"wr_oor",    0, 4'hF, 3'b000, 32'h10004,    32'hDEADBEEF, 11'h006, 1, 32'h0};
        tbl[8]  = '{"rd_after",  1, 4'h0, 3'b000, 32'h4,        32'h0,        11'h007, 0, 32'h55667788};
        tbl[9]  = '{"rd_wr",     1, 4'h3, 3'b000, 32'h300,      32'hCAFEBEEF, 11'h008, 1, 32'h0};
        tbl[10] = '{"rd_300",    1, 4'h0, 3'b000, 32'h300,      32'h0,        11'h009, 0, 32'h0000BEEF};
        tbl[11] = '{"m_inv",     0, 4'h0, 3'b001, 32'h0,        32'h0,        11'h00A, 0, 32'h0};
        tbl[12] = '{"m_inv_fl",  0, 4'h0, 3'b101, 32'h0,        32'h0,        11'h00B, 1, 32'h0};
        tbl[13] = '{"m_wb",      0, 4'h0, 3'b010, 32'h0,        32'h0,        11'h00C, 0, 32'h0};

        rst_n = 1'b0;
        i_rd = 0; i_flush = 0; i_inv = 0; i_pc = 0; d_cache = 0;
        bd_wr = 0; bd_addr = 0; bd_data = 0;
        d_drive(0, 0, 0, 0, 0, 0);
        tick(); tick();

        // Reset state
        chk("rst.i_valid", i_vld, 0);
        chk("rst.i_error", i_err, 0);
        chk("rst.i_inst",  i_inst, 0);
        chk("rst.d_ack",   d_ack, 0);
        chk("rst.d_error", d_err, 0);
        chk("rst.d_data",  d_rdata, 0);
        chk("rst.d_tag",   d_rtag, 0);
        rst_n = 1'b1;
        tick();
`ifndef TCM_MEM_STALL_EN
        chk("acc.i", i_acc, 1);
        chk("acc.d", d_acc, 1);
`endif

        // Image load
        bd(32'h0, 32'h11223344);
        bd(32'h4, 32'h55667788);
        bd(32'h100, 32'h0); bd(32'h300, 32'h0);
        bd(32'h400, 32'h0); bd(32'h404, 32'h0);

        fetch_chk("i_pc4",  32'h4,     0, 64'h5566778811223344);
        fetch_chk("i_oor",  32'h10000, 1, 64'h0);

`ifndef TCM_MEM_STALL_EN
        // Back-to-back write then read of the same word
        d_drive(0, 4'b0101, 0, 32'h100, 32'hAABBCCDD, 11'h3A5);
        tick();
        d_drive(1, 4'b0000, 0, 32'h100, 32'h0, 11'h0C1);
        tick();
        d_drive(0, 0, 0, 0, 0, 0);
        chk("wr100.ack",  d_ack, 1);
        chk("wr100.tag",  d_rtag, 11'h3A5);
        chk("wr100.data", d_rdata, 0);
        chk("wr100.err",  d_err, 0);
        tick();
        chk("rd100.ack",  d_ack, 1);
        chk("rd100.tag",  d_rtag, 11'h0C1);
        chk("rd100.data", d_rdata, 32'h00BB00DD);
        tick();
`endif

        for (int i = 0; i < 14; i++) d_txn(tbl[i]);

`ifndef TCM_MEM_STALL_EN
        // Read-during-write: fetch and D read of a word being backdoor-written
        bd_wr = 1; bd_addr = 32'h400; bd_data = 32'h0BADF00D;
        d_drive(1, 0, 0, 32'h400, 0, 11'h044);
        i_rd = 1; i_pc = 32'h400;
        tick();
        bd_wr = 0; i_rd = 0;
        d_drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("rdw.d_ack",  d_ack, 1);
        chk("rdw.d_data", d_rdata, 0);
        tick();
        chk("rdw.i_vld",  i_vld, 1);
        chk("rdw.i_inst", i_inst, 0);
        repeat (3) tick();
        d_txn('{"rdw_new", 1, 4'h0, 3'b000, 32'h400, 32'h0, 11'h045, 0, 32'h0BADF00D});

        // Backdoor and data-port write to the same word in one cycle
        bd_wr = 1; bd_addr = 32'h500; bd_data = 32'h01020304;
        d_drive(0, 4'hF, 0, 32'h500, 32'hFFFFFFFF, 11'h046);
        tick();
        bd_wr = 0;
        d_drive(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        d_txn('{"bd_wins", 1, 4'h0, 3'b000, 32'h500, 32'h0, 11'h047, 0, 32'h01020304});

        // Flush: four consecutive fetches, flush with the third
        cnt3 = 0; cnt4 = 0; at3 = -1; at4 = -1; inst3 = '0; inst4 = '0;
        i_rd = 1; i_pc = 32'h0;
        tick(); cnt3 += int'(i_vld); cnt4 += int'(i4_vld);
        i_pc = 32'h8;
        tick(); cnt3 += int'(i_vld); cnt4 += int'(i4_vld);
        i_pc = 32'h100; i_flush = 1;
        tick(); cnt3 += int'(i_vld); cnt4 += int'(i4_vld);
        i_pc = 32'h0; i_flush = 0;
        tick();
        i_rd = 0;
        for (int k = 0; k < 10; k++) begin
            if (i_vld)  begin cnt3++; at3 = k; inst3 = i_inst;  end
            if (i4_vld) begin cnt4++; at4 = k; inst4 = i4_inst; end
            tick();
        end
        chk("flush.cnt3",  cnt3, 1);
        chk("flush.at3",   at3, 2);
        chk("flush.inst3", inst3, 64'h5566778811223344);
        chk("flush.cnt4",  cnt4, 1);
        chk("flush.at4",   at4, 3);
        chk("flush.inst4", inst4, 64'h5566778811223344);

        // Reset with two D responses in flight
        d_drive(1, 0, 0, 32'h0, 0, 11'h010);
        tick();
        d_drive(1, 0, 0, 32'h4, 0, 11'h011);
        tick();
        d_drive(0, 0, 0, 0, 0, 0);
        chk("rstf.pre_ack", d_ack, 1);
        chk("rstf.pre_tag", d_rtag, 11'h010);
        #1 rst_n = 1'b0;
        #1;
        chk("rstf.ack",  d_ack, 0);
        chk("rstf.tag",  d_rtag, 0);
        chk("rstf.data", d_rdata, 0);
        tick(); tick();
        rst_n = 1'b1;
        cnt3 = 0;
        for (int k = 0; k < 6; k++) begin
            cnt3 += int'(d_ack);
            tick();
        end
        chk("rstf.stale_ack", cnt3, 0);
        d_txn('{"rstf_ram", 1, 4'h0, 3'b000, 32'h0, 32'h0, 11'h012, 0, 32'h11223344});
`endif

`ifdef TCM_MEM_STALL_EN
        begin
            int acc_n = 0;
            int cyc   = 0;
            int got   = 0;
            logic [31:0] exp_d;
            fork
                begin
                    for (int i = 0; i < 1000; i++) begin
                        d_drive(1, 0, 0, (i % 2 == 1) ? 32'h4 : 32'h0, 0, 11'(i));
                        while (!d_acc && cyc < 20000) begin tick(); cyc++; end
                        tick(); cyc++; acc_n++;
                    end
                    d_drive(0, 0, 0, 0, 0, 0);
                end
                begin
                    int t = 0;
                    while (got < 1000 && t < 25000) begin
                        tick(); t++;
                        if (d_ack) begin
                            exp_d = (got % 2 == 1) ? 32'h55667788 : 32'h11223344;
                            chk("stall.tag",  d_rtag, 11'(got));
                            chk("stall.data", d_rdata, exp_d);
                            got++;
                        end
                    end
                end
            join
            repeat (4) begin
                tick();
                if (d_ack) got++;
            end
            chk("stall.accepted", acc_n, 1000);
            chk("stall.responses", got, 1000);
            chk("stall.rate", (acc_n * 100 >= 70 * cyc) && (acc_n * 100 <= 80 * cyc), 1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
